cmp_scan_ctrl: RTL and testbench
================================

Name: cmp_scan_ctrl

Overview:
- Sequencing controller that time-multiplexes a single external 16-bit equality comparator (compeq16) across a small local table of 16-bit entries.
- On start, it compares a 16-bit key against table entries 0..DEPTH-1, one entry per clock, and reports whether a hit occurred and the index of the first hit.
- Sits between game/control logic and the shared comparator; for example, it matches a paddle or ball position against a list of stored coordinates.

Parameters:
- DEPTH, 8, number of table entries; 2..16.
- IDX_W, 3, index width; must equal ceil(log2(DEPTH)).

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- wr_en  in  1  table write strobe.
- wr_addr  in  IDX_W  table write index.
- wr_data  in  16  table write data.
- start  in  1  begin a scan; sampled only in IDLE.
- key  in  16  search key; captured on the edge that accepts start.
- cmp_eq  in  1  eq output of the external compeq16.
- cmp_a  out  16  operand a to compeq16 (registered key).
- cmp_b  out  16  operand b to compeq16 (table[idx]).
- busy  out  1  high while in SCAN or DONE.
- done  out  1  one-cycle completion pulse.
- found  out  1  result: at least one entry matched.
- match_idx  out  IDX_W  index of the first matching entry.

Behaviour:
- Reset is async and active-high. It forces:
  - state to IDLE and idx to 0;
  - key_reg, all table entries, cmp_a, cmp_b to 0;
  - busy, done, found, match_idx to 0.
- Asserting reset mid-scan aborts the scan immediately. No done pulse is produced.
- States:
  - IDLE: busy=0. If start=1, capture key into key_reg, clear found and match_idx, set idx=0, go to SCAN.
  - SCAN: busy=1.
    - cmp_a=key_reg and cmp_b=table[idx], both combinational from registers; cmp_eq is sampled in the same cycle.
    - If cmp_eq=1: found<=1, match_idx<=idx, go to DONE.
    - Else if idx==DEPTH-1: found stays 0, go to DONE.
    - Else idx<=idx+1.
  - DONE: busy=1, done=1 for exactly this one cycle, then go to IDLE.
- Latency, with edge 0 being the edge that accepts start:
  - Entry k is compared during the cycle following edge k.
  - Hit at k: done is high in the cycle following edge k+1.
  - Full miss: done is high in the cycle following edge DEPTH.
- found and match_idx are stable from DONE until the next accepted start. They are valid whenever done=1 and afterwards.
- Table writes:
  - Accepted only in IDLE. wr_en while busy is dropped, and the table is unchanged.
  - A write and a start in the same IDLE cycle are both accepted. The scan sees the new value.
- start while busy is ignored. There is no queuing.
- idx never wraps. DEPTH-1 is the terminal compare.
- In IDLE, cmp_a and cmp_b hold their last values so the comparator does not toggle.

Optional Feature:
- Macro: MATCH_COUNT_EN.
- Defined:
  - Adds output match_cnt [IDX_W:0], reset to 0 and cleared on an accepted start.
  - SCAN never exits early. It always visits all DEPTH entries and increments match_cnt on each cmp_eq=1.
  - found=1 if any hit; match_idx is still the first hit index.
  - done is always in the cycle following edge DEPTH.
- Undefined: no match_cnt port; the early-exit behaviour above applies.

Test Plan:
- Reset: assert reset mid-scan at entry 3 -> busy=0, done never pulses, found=0, match_idx=0, and every table entry reads back as miss for key 0x0001.
- Hit: load table[i]=0x1000+i, start with key=0x1005 -> done after 6 edges, found=1, match_idx=5, done high exactly 1 cycle.
- Miss: same table, key=0xBEEF -> done after 8 edges (DEPTH=8), found=0, match_idx=0.
- Duplicates: table[2]=table[6]=0xAAAA, key=0xAAAA -> match_idx=2. With MATCH_COUNT_EN: match_cnt=2, done after 8 edges.
- Busy protection: during a scan, pulse start with key=0x1001 and write wr_addr=7, wr_data=0xFFFF -> scan result unchanged, table[7] still 0x1007, and no second done pulse.
- Back-to-back and boundary: start again in the cycle after done with key=0x1000 -> accepted, found=1, match_idx=0, done after 1 edge. Key=0x1007 -> match_idx=7.

Source files
------------

// File: rtl/cmp_scan_ctrl.sv
// Scans a small local table against a key through one shared external 16-bit equality comparator.
// Optional MATCH_COUNT_EN: scan never exits early, and match_cnt counts every hit.
module cmp_scan_ctrl #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned IDX_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_addr,
    input  logic [15:0]      wr_data,
    input  logic             start,
    input  logic [15:0]      key,
    input  logic             cmp_eq,
    output logic [15:0]      cmp_a,
    output logic [15:0]      cmp_b,
    output logic             busy,
    output logic             done,
    output logic             found,
`ifdef MATCH_COUNT_EN
    output logic [IDX_W:0]   match_cnt,
`endif
    output logic [IDX_W-1:0] match_idx
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);
    localparam logic [IDX_W:0]   DEPTH_L  = (IDX_W + 1)'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;

    state_t           r_state;
    logic [IDX_W-1:0] r_idx;
    logic [15:0]      r_key;
    logic [15:0]      r_table [DEPTH];
    logic [15:0]      r_cmp_b;
    logic             r_busy;
    logic             r_done;
    logic             r_found;
    logic [IDX_W-1:0] r_match_idx;
`ifdef MATCH_COUNT_EN
    logic [IDX_W:0]   r_match_cnt;
`endif

    logic             w_wr_ok;
    logic [15:0]      w_first_b;

    assign w_wr_ok = wr_en && ({1'b0, wr_addr} < DEPTH_L);
    // A write to entry 0 in the accepting cycle must be visible to the first compare.
    assign w_first_b = (w_wr_ok && (wr_addr == '0)) ? wr_data : r_table[0];

    assign cmp_a     = r_key;
    assign cmp_b     = r_cmp_b;
    assign busy      = r_busy;
    assign done      = r_done;
    assign found     = r_found;
    assign match_idx = r_match_idx;
`ifdef MATCH_COUNT_EN
    assign match_cnt = r_match_cnt;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_idx       <= '0;
            r_key       <= '0;
            r_cmp_b     <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_found     <= 1'b0;
            r_match_idx <= '0;
`ifdef MATCH_COUNT_EN
            r_match_cnt <= '0;
`endif
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_table[i] <= '0;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_busy <= 1'b0;
                    r_done <= 1'b0;
                    if (w_wr_ok) begin
                        r_table[wr_addr] <= wr_data;
                    end
                    if (start) begin
                        r_key       <= key;
                        r_cmp_b     <= w_first_b;
                        r_found     <= 1'b0;
                        r_match_idx <= '0;
                        r_idx       <= '0;
                        r_busy      <= 1'b1;
`ifdef MATCH_COUNT_EN
                        r_match_cnt <= '0;
`endif
                        r_state     <= S_SCAN;
                    end
                end
                S_SCAN: begin
`ifdef MATCH_COUNT_EN
                    if (cmp_eq) begin
                        r_match_cnt <= r_match_cnt + 1'b1;
                        if (!r_found) begin
                            r_found     <= 1'b1;
                            r_match_idx <= r_idx;
                        end
                    end
                    if (r_idx == LAST_IDX) begin
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_idx   <= r_idx + 1'b1;
                        r_cmp_b <= r_table[r_idx + 1'b1];
                    end
`else
                    if (cmp_eq) begin
                        r_found     <= 1'b1;
                        r_match_idx <= r_idx;
                        r_done      <= 1'b1;
                        r_state     <= S_DONE;
                    end else if (r_idx == LAST_IDX) begin
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_idx   <= r_idx + 1'b1;
                        r_cmp_b <= r_table[r_idx + 1'b1];
                    end
`endif
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cmp_scan_ctrl.sv
// Scoreboard bench for cmp_scan_ctrl: the driver queues expected results, and a monitor checks each done pulse.
module tb_cmp_scan_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [15:0] wr_data;
    logic        start;
    logic [15:0] key;
    logic        cmp_eq;
    logic [15:0] cmp_a;
    logic [15:0] cmp_b;
    logic        busy;
    logic        done;
    logic        found;
    logic [2:0]  match_idx;
`ifdef MATCH_COUNT_EN
    logic [3:0]  match_cnt;
`endif

    int unsigned checks   = 0;
    int unsigned failures = 0;
    int unsigned cyc      = 0;

    typedef struct {
        logic        found;
        logic [2:0]  idx;
        int unsigned cyc;
        int unsigned cnt;
    } exp_t;

    exp_t sb[$];

    cmp_scan_ctrl #(.DEPTH(8), .IDX_W(3)) dut (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .start     (start),
        .key       (key),
        .cmp_eq    (cmp_eq),
        .cmp_a     (cmp_a),
        .cmp_b     (cmp_b),
        .busy      (busy),
        .done      (done),
        .found     (found),
`ifdef MATCH_COUNT_EN
        .match_cnt (match_cnt),
`endif
        .match_idx (match_idx)
    );

    // Stand-in for the external compeq16.
    assign cmp_eq = (cmp_a == cmp_b);

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Edges from start acceptance to the done cycle for a hit at entry k.
    function automatic int unsigned lat_hit(input int unsigned k);
`ifdef MATCH_COUNT_EN
        return 8;
`else
        return k + 1;
`endif
    endfunction

    always @(negedge clk) begin
        if (!reset && done) begin
            if (sb.size() == 0) begin
                chk("done_unexpected", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("found", 32'(found), 32'(e.found));
                chk("match_idx", 32'(match_idx), 32'(e.idx));
                chk("done_latency", cyc, e.cyc);
                chk("busy_in_done", 32'(busy), 1);
`ifdef MATCH_COUNT_EN
                chk("match_cnt", 32'(match_cnt), e.cnt);
`endif
            end
        end
    end

    task automatic wr(input logic [2:0] a, input logic [15:0] d);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic scan(input logic [15:0] k, input logic do_wr, input logic [2:0] wa,
                        input logic [15:0] wd, input logic ef, input logic [2:0] ei,
                        input int unsigned lat, input int unsigned cnt);
        exp_t e;
        @(negedge clk);
        start = 1'b1; key = k;
        wr_en = do_wr; wr_addr = wa; wr_data = wd;
        e.found = ef; e.idx = ei; e.cyc = cyc + 1 + lat; e.cnt = cnt;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0; wr_en = 1'b0;
    endtask

    task automatic wait_done();
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            seen = done;
        end
        if (!seen) chk("done_timeout", 0, 1);
    endtask

    initial begin
        reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; start = 1'b0; key = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_found", 32'(found), 0);
        chk("rst_idx", 32'(match_idx), 0);
        chk("rst_cmp_a", 32'(cmp_a), 0);
        chk("rst_cmp_b", 32'(cmp_b), 0);
        reset = 1'b0;

        for (int i = 0; i < 8; i++) wr(3'(i), 16'h1000 + 16'(i));

        scan(16'h1005, 0, 0, 0, 1, 5, lat_hit(5), 1);
        wait_done();
        scan(16'hBEEF, 0, 0, 0, 0, 0, 8, 0);
        wait_done();

        // Start and a table write while busy must both be dropped.
        scan(16'h1003, 0, 0, 0, 1, 3, lat_hit(3), 1);
        start = 1'b1; key = 16'h1001; wr_en = 1'b1; wr_addr = 3'd7; wr_data = 16'hFFFF;
        @(negedge clk);
        start = 1'b0; wr_en = 1'b0;
        wait_done();
        repeat (4) @(negedge clk);

        scan(16'h1007, 0, 0, 0, 1, 7, 8, 1);
        wait_done();
        scan(16'h1000, 0, 0, 0, 1, 0, lat_hit(0), 1);
        wait_done();
        scan(16'h1007, 0, 0, 0, 1, 7, 8, 1);
        wait_done();

        wr(3'd2, 16'hAAAA);
        wr(3'd6, 16'hAAAA);
        scan(16'hAAAA, 0, 0, 0, 1, 2, lat_hit(2), 2);
        wait_done();

        // Write and start in the same idle cycle; the scan must see the new entry.
        scan(16'h5555, 1, 3'd4, 16'h5555, 1, 4, lat_hit(4), 1);
        wait_done();

        // Reset while entry 3 is being compared.
        scan(16'h1007, 0, 0, 0, 1, 7, 8, 1);
        repeat (3) @(negedge clk);
        chk("pre_rst_busy", 32'(busy), 1);
        reset = 1'b1;
        sb.delete();
        #1;
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_done", 32'(done), 0);
        chk("mid_rst_found", 32'(found), 0);
        chk("mid_rst_idx", 32'(match_idx), 0);
        chk("mid_rst_cmp_a", 32'(cmp_a), 0);
        chk("mid_rst_cmp_b", 32'(cmp_b), 0);
        repeat (3) @(negedge clk);
        chk("rst_hold_done", 32'(done), 0);
        reset = 1'b0;

        scan(16'h0001, 0, 0, 0, 0, 0, 8, 0);
        wait_done();

        repeat (4) @(negedge clk);
        chk("sb_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
